rd_preamble_seq: RTL and testbench
==================================

// Module: rd_preamble_seq
// PURPOSE
//  Read-path sequencer for the Data Manager. Queues accepted read commands and times
//  each one's DQS preamble search window from read latency and preamble setting.
//  Detects the DQS "10" preamble pattern on DQS_AD_i, then opens the data capture
//  window for one burst. Reports completion, or a timeout if no preamble arrives.
// PARAMETERS
//  CMD_DEPTH  4   max outstanding read commands (power of 2, >=2)
//  RL_W       6   width of read-latency input, in clk_i cycles
//  TO_CYC     16  preamble search window length, in cycles (>=2)
//  BL_CYC     8   capture window length per burst, in cycles (BL16 on DDR)
// PORTS
//  clk_i              in   1                   clock
//  reset_n_i          in   1                   async active-low reset
//  en_i               in   1                   block enable; low = abort + flush
//  rd_cmd_i           in   1                   read command strobe; accepted when rd_cmd_ready_o=1
//  rd_cmd_ready_o     out  1                   en_i && queue not full
//  rl_i               in   RL_W                read latency in cycles, sampled at accept
//  pre_amble_sett_i   in   3                   preamble setting, sampled at accept
//  DQS_AD_i           in   1                   sampled DQS level
//  det_en_o           out  1                   high while searching for preamble (WAIT_PRE)
//  capture_en_o       out  1                   high during data capture (CAPTURE)
//  burst_done_o       out  1                   1-cycle pulse after last capture cycle
//  timeout_o          out  1                   1-cycle pulse after window expiry with no preamble
//  busy_o             out  1                   state!=IDLE or queue not empty
//  cmd_cnt_o          out  $clog2(CMD_DEPTH+1) queued entries, including the active one
// BEHAVIOUR
//  Reset: all outputs 0, except rd_cmd_ready_o = en_i. Queue empty, state IDLE, shift reg 00.
//  Preamble length pre_len: sett 0..3 -> sett+1; sett 4..7 -> 4.
//  Push on rd_cmd_i && rd_cmd_ready_o. Entry delay = max(rl_i - pre_len, 0), unsigned and clamped.
//  Full queue: no push, even when a pop happens in the same cycle.
//  Every valid entry's delay decrements by 1 each cycle and saturates at 0.
//  Head = oldest entry. Pop happens only on burst completion or timeout.
//  FSM states: IDLE, WAIT_PRE, CAPTURE.
//  IDLE -> WAIT_PRE when en_i && queue non-empty && head delay==0.
//   On entry: shift reg s cleared to 00, window counter cleared to 0.
//  WAIT_PRE: det_en_o=1. Each cycle s <= {s[0], DQS_AD_i}.
//   Detection uses the registered value: s==2'b10 (older=1, newer=0) -> CAPTURE next cycle.
//   Otherwise, if window count == TO_CYC-1 -> pop, IDLE, timeout_o=1 in the next cycle.
//   Detection has priority over timeout when both occur in the same cycle.
//  CAPTURE: capture_en_o=1 for exactly BL_CYC cycles.
//   On the last cycle: pop, go to IDLE; burst_done_o=1 in the next (IDLE) cycle.
//  Always at least 1 IDLE cycle between operations.
//  A head that reaches delay 0 while busy starts as soon as the FSM is in IDLE (late start, no error).
//  Latency: det_en_o first high at cycle A + max(rl - pre_len, 0) + 2,
//   where A = accept cycle and the head was idle and unblocked.
//  en_i low in any cycle:
//   - next cycle: state IDLE, queue flushed, det_en_o=0, capture_en_o=0;
//   - no burst_done_o or timeout_o pulse;
//   - rd_cmd_i ignored while en_i is low.
//  burst_done_o and timeout_o are never both high in the same cycle.
//  Async reset mid-operation: immediate return to reset state; queued commands are lost.
// TESTING
//  T1 RL=10, sett=1, accept@0; DQS_AD_i=1@11, 0@12 ->
//     det_en_o 10..13, capture_en_o 14..21, burst_done_o @22 only.
//  T2 same command, DQS_AD_i held 0 ->
//     det_en_o 10..25, timeout_o @26, capture_en_o never high, cmd_cnt_o 1->0.
//  T3 5 rd_cmd_i in cycles 0..4, DEPTH=4 ->
//     4 accepted, rd_cmd_ready_o=0 @4, cmd_cnt_o=4;
//     bursts serviced in order with 1 IDLE gap between them.
//  T4 rl=1, sett=3, accept@0 -> delay clamps to 0, det_en_o high @2.
//  T5 en_i dropped mid-CAPTURE with 2 queued ->
//     capture_en_o=0 next cycle, cmd_cnt_o=0, no pulses, busy_o=0.
//  T6 reset_n_i asserted during WAIT_PRE ->
//     all outputs 0 immediately; after release a new command runs as in T1.

Source files
------------

// File: rtl/rd_preamble_seq_if.sv
// rd_preamble_seq_if: read command channel into the preamble sequencer
interface rd_preamble_seq_if #(
   parameter int RL_W = 6
) ();
   logic            rd_cmd_i;
   logic            rd_cmd_ready_o;
   logic [RL_W-1:0] rl_i;
   logic [2:0]      pre_amble_sett_i;
   modport master (output rd_cmd_i, rl_i, pre_amble_sett_i, input rd_cmd_ready_o);
   modport slave  (input rd_cmd_i, rl_i, pre_amble_sett_i, output rd_cmd_ready_o);
endinterface

// File: rtl/rd_preamble_seq.sv
// rd_preamble_seq: queues read commands, times each DQS preamble search window,
// detects the "10" preamble and opens one burst capture window per command.
module rd_preamble_seq #(
   parameter int CMD_DEPTH = 4,
   parameter int RL_W      = 6,
   parameter int TO_CYC    = 16,
   parameter int BL_CYC    = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           en_i,
   rd_preamble_seq_if.slave               cmd,
   input  logic                           DQS_AD_i,
   output logic                           det_en_o,
   output logic                           capture_en_o,
   output logic                           burst_done_o,
   output logic                           timeout_o,
   output logic                           busy_o,
   output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_cnt_o
);
   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int QC_W  = $clog2(CMD_DEPTH+1);
   localparam int CNT_W = $clog2(TO_CYC > BL_CYC ? TO_CYC : BL_CYC);
   typedef enum logic [1:0] {IDLE, WAIT_PRE, CAPTURE} state_t;
   state_t           state, state_nxt;
   logic [RL_W-1:0]  dly [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [QC_W-1:0]  cnt_q;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       s, s_nxt;
   logic [RL_W-1:0]  pre_len, new_dly;
   logic             push, pop, done_nxt, to_nxt;
   assign pre_len = cmd.pre_amble_sett_i[2] ? RL_W'(4) : RL_W'(cmd.pre_amble_sett_i[1:0]) + RL_W'(1);
   assign new_dly = cmd.rl_i > pre_len ? cmd.rl_i - pre_len : '0;
   assign cmd.rd_cmd_ready_o = en_i && cnt_q != QC_W'(CMD_DEPTH);
   assign push = cmd.rd_cmd_i && cmd.rd_cmd_ready_o;
   assign det_en_o = state == WAIT_PRE;
   assign capture_en_o = state == CAPTURE;
   assign busy_o = state != IDLE || cnt_q != '0;
   assign cmd_cnt_o = cnt_q;
   // One counter serves both the search window and the capture window.
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      s_nxt = s;
      pop = 1'b0;
      done_nxt = 1'b0;
      to_nxt = 1'b0;
      case (state)
         IDLE: if (cnt_q != '0 && dly[rd_ptr] == '0) begin
            state_nxt = WAIT_PRE;
            cnt_nxt = '0;
            s_nxt = '0;
         end
         WAIT_PRE: begin
            s_nxt = {s[0], DQS_AD_i};
            cnt_nxt = cnt + CNT_W'(1);
            if (s == 2'b10) begin
               state_nxt = CAPTURE;
               cnt_nxt = '0;
            end else if (cnt == CNT_W'(TO_CYC-1)) begin
               state_nxt = IDLE;
               pop = 1'b1;
               to_nxt = 1'b1;
            end
         end
         CAPTURE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(BL_CYC-1)) begin
               state_nxt = IDLE;
               pop = 1'b1;
               done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!en_i) begin
         state_nxt = IDLE;
         pop = 1'b0;
         done_nxt = 1'b0;
         to_nxt = 1'b0;
      end
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state <= IDLE;
         cnt <= '0;
         s <= '0;
         burst_done_o <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         s <= s_nxt;
         burst_done_o <= done_nxt;
         timeout_o <= to_nxt;
      end
   // Delays count down in place; a fresh entry starts at its full delay.
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         for (int i = 0; i < CMD_DEPTH; i++) dly[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q <= '0;
      end else if (!en_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < CMD_DEPTH; i++) dly[i] <= dly[i] == '0 ? '0 : dly[i] - RL_W'(1);
         if (push) dly[wr_ptr] <= new_dly;
         wr_ptr <= wr_ptr + PTR_W'(push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         cnt_q <= cnt_q + QC_W'(push) - QC_W'(pop);
      end
endmodule

// File: tb/tb_rd_preamble_seq.sv
// tb_rd_preamble_seq: directed scenarios plus random traffic checked against
// a transaction-level model (absolute ready times, window start cycles).
module tb_rd_preamble_seq;
   localparam int DEPTH = 4, RL_W = 6, TO_CYC = 16, BL_CYC = 8, N = 500;
   logic clk_i = 1'b0, reset_n_i = 1'b0, en_i = 1'b0, DQS_AD_i = 1'b0;
   logic det_en_o, capture_en_o, burst_done_o, timeout_o, busy_o;
   logic [2:0] cmd_cnt_o;
   int checks = 0, errors = 0;
   logic st_en [N], st_cmd [N], st_dqs [N];
   int st_rl [N], st_sett [N];
   int obs_ready [N], obs_cnt [N], obs_busy [N], obs_cap [N];
   int first_det, first_cap, first_done, first_to;
   rd_preamble_seq_if #(.RL_W(RL_W)) cmd ();
   rd_preamble_seq #(.CMD_DEPTH(DEPTH), .RL_W(RL_W), .TO_CYC(TO_CYC), .BL_CYC(BL_CYC)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .cmd(cmd.slave), .DQS_AD_i(DQS_AD_i),
      .det_en_o(det_en_o), .capture_en_o(capture_en_o), .burst_done_o(burst_done_o),
      .timeout_o(timeout_o), .busy_o(busy_o), .cmd_cnt_o(cmd_cnt_o));
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic check_idle_outputs(input string tag, input int ready_exp);
      check({tag, "_det"}, det_en_o, 0);
      check({tag, "_cap"}, capture_en_o, 0);
      check({tag, "_done"}, burst_done_o, 0);
      check({tag, "_to"}, timeout_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_cnt"}, cmd_cnt_o, 0);
      check({tag, "_ready"}, cmd.rd_cmd_ready_o, ready_exp);
   endtask
   task automatic reset_dut();
      reset_n_i = 1'b0;
      en_i = 1'b1;
      cmd.rd_cmd_i = 1'b0;
      cmd.rl_i = '0;
      cmd.pre_amble_sett_i = '0;
      DQS_AD_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check_idle_outputs("rst", 1);
      reset_n_i = 1'b1;
   endtask
   task automatic clear_stim();
      for (int c = 0; c < N; c++) begin
         st_en[c] = 1'b1;
         st_cmd[c] = 1'b0;
         st_dqs[c] = 1'b0;
         st_rl[c] = 0;
         st_sett[c] = 0;
      end
   endtask
   task automatic put_cmd(input int c, input int rl, input int sett);
      st_cmd[c] = 1'b1;
      st_rl[c] = rl;
      st_sett[c] = sett;
   endtask
   // Model: each queued command becomes launchable at an absolute cycle;
   // the search window is judged by looking back into the DQS stimulus.
   task automatic run(input int n);
      int q[$];
      int mode = 0, w = 0, cs = 0, pl, d;
      bit pd = 0, pt = 0, nd, nt, rdy;
      first_det = -1;
      first_cap = -1;
      first_done = -1;
      first_to = -1;
      for (int c = 0; c < n; c++) begin
         @(posedge clk_i);
         #1;
         en_i = st_en[c];
         cmd.rd_cmd_i = st_cmd[c];
         cmd.rl_i = RL_W'(st_rl[c]);
         cmd.pre_amble_sett_i = 3'(st_sett[c]);
         DQS_AD_i = st_dqs[c];
         @(negedge clk_i);
         rdy = st_en[c] && q.size() < DEPTH;
         check($sformatf("det_en@%0d", c), det_en_o, int'(mode == 1));
         check($sformatf("capture_en@%0d", c), capture_en_o, int'(mode == 2));
         check($sformatf("burst_done@%0d", c), burst_done_o, int'(pd));
         check($sformatf("timeout@%0d", c), timeout_o, int'(pt));
         check($sformatf("cmd_cnt@%0d", c), cmd_cnt_o, q.size());
         check($sformatf("busy@%0d", c), busy_o, int'(mode != 0 || q.size() != 0));
         check($sformatf("ready@%0d", c), cmd.rd_cmd_ready_o, int'(rdy));
         obs_ready[c] = cmd.rd_cmd_ready_o;
         obs_cnt[c] = cmd_cnt_o;
         obs_busy[c] = busy_o;
         obs_cap[c] = capture_en_o;
         if (det_en_o && first_det < 0) first_det = c;
         if (capture_en_o && first_cap < 0) first_cap = c;
         if (burst_done_o && first_done < 0) first_done = c;
         if (timeout_o && first_to < 0) first_to = c;
         nd = 0;
         nt = 0;
         if (mode == 0 && st_en[c] && q.size() > 0 && c >= q[0]) begin
            mode = 1;
            w = c + 1;
         end else if (mode == 1 && c >= w + 2 && st_dqs[c-2] && !st_dqs[c-1]) begin
            mode = 2;
            cs = c + 1;
         end else if (mode == 1 && c == w + TO_CYC - 1) begin
            mode = 0;
            void'(q.pop_front());
            nt = 1;
         end else if (mode == 2 && c == cs + BL_CYC - 1) begin
            mode = 0;
            void'(q.pop_front());
            nd = 1;
         end
         if (st_cmd[c] && rdy) begin
            pl = st_sett[c] > 3 ? 4 : st_sett[c] + 1;
            d = st_rl[c] > pl ? st_rl[c] - pl : 0;
            q.push_back(c + 1 + d);
         end
         if (!st_en[c]) begin
            mode = 0;
            q.delete();
            nd = 0;
            nt = 0;
         end
         pd = nd;
         pt = nt;
      end
   endtask
   initial begin
      cmd.rd_cmd_i = 1'b0;
      cmd.rl_i = '0;
      cmd.pre_amble_sett_i = '0;
      // T1: preamble found, one full burst
      reset_dut();
      clear_stim();
      put_cmd(0, 10, 1);
      st_dqs[11] = 1'b1;
      run(40);
      check("t1_first_det", first_det, 10);
      check("t1_first_cap", first_cap, 14);
      check("t1_done", first_done, 22);
      check("t1_no_timeout", first_to, -1);
      // T2: no preamble, window expires
      reset_dut();
      clear_stim();
      put_cmd(0, 10, 1);
      run(40);
      check("t2_first_det", first_det, 10);
      check("t2_timeout", first_to, 26);
      check("t2_no_cap", first_cap, -1);
      check("t2_cnt25", obs_cnt[25], 1);
      check("t2_cnt26", obs_cnt[26], 0);
      // T3: overfill the queue, bursts drain in order
      reset_dut();
      clear_stim();
      for (int i = 0; i < 5; i++) put_cmd(i, 10, 1);
      for (int c = 0; c < N; c++) st_dqs[c] = (c % 4 == 1);
      run(200);
      check("t3_ready4", obs_ready[4], 0);
      check("t3_cnt4", obs_cnt[4], 4);
      check("t3_cnt_end", obs_cnt[199], 0);
      // T4: latency shorter than preamble clamps to zero delay
      reset_dut();
      clear_stim();
      put_cmd(0, 1, 3);
      run(30);
      check("t4_first_det", first_det, 2);
      // T5: enable dropped mid-capture with a second command queued
      reset_dut();
      clear_stim();
      put_cmd(0, 10, 1);
      put_cmd(1, 10, 1);
      st_dqs[11] = 1'b1;
      for (int c = 16; c < 20; c++) st_en[c] = 1'b0;
      run(40);
      check("t5_cap16", obs_cap[16], 1);
      check("t5_cap17", obs_cap[17], 0);
      check("t5_cnt17", obs_cnt[17], 0);
      check("t5_busy17", obs_busy[17], 0);
      check("t5_no_done", first_done, -1);
      // T6: async reset while searching, then a clean rerun
      reset_dut();
      clear_stim();
      put_cmd(0, 10, 1);
      st_dqs[11] = 1'b1;
      run(12);
      check("t6_searching", det_en_o, 1);
      #1 reset_n_i = 1'b0;
      #1 check_idle_outputs("t6_async", 1);
      reset_dut();
      run(40);
      check("t6_rerun_det", first_det, 10);
      check("t6_rerun_done", first_done, 22);
      // Random traffic
      for (int it = 0; it < 4; it++) begin
         reset_dut();
         for (int c = 0; c < N; c++) begin
            st_en[c] = ($urandom_range(63) != 0);
            st_cmd[c] = ($urandom_range(5) == 0);
            st_rl[c] = $urandom_range(24);
            st_sett[c] = $urandom_range(7);
            st_dqs[c] = ($urandom_range(9) == 0);
         end
         run(N);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
